mux_4to1_rr_arbiter: RTL and testbench
======================================

// Module: mux_4to1_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for the shared 4:1 WIDTH-bit select datapath.
//  Four valid/ready/last source channels compete for one registered output
//  channel. A granted source keeps the path for a whole burst, which ends on
//  in_last or a forced release at MAX_BURST beats. Drives the mux select
//  (out_sel) and registers the selected word.
// PARAMETERS
//  WIDTH      16  data width of each source and of out_data
//  SEL_WIDTH  2   select width; fixed at 2 (four sources)
//  MAX_BURST  16  beats per grant before forced release; >=1
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   4          per-source beat valid; bit i = data<i>
//  in_last    in   4          per-source last-beat-of-burst flag
//  data0..3   in   WIDTH      source data words
//  in_ready   out  4          per-source accept, combinational, one-hot or 0
//  out_valid  out  1          registered output beat valid
//  out_data   out  WIDTH      registered selected word
//  out_last   out  1          burst end (in_last or forced release)
//  out_sel    out  SEL_WIDTH  source index of the current out beat
//  out_ready  in   1          downstream accept
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is asynchronous and active-high.
//  Reset: out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE,
//   ptr=3 (source 0 wins first), beat_cnt=0. in_ready is 0 while rst=1.
//  load = !out_valid | out_ready; output register loads only when load=1.
//  States:
//   IDLE: if load and any in_valid, pick winner g = first set bit searching
//     ptr+1, ptr+2, ... (mod 4).
//     - in_ready[g]=1 the same cycle.
//     - Register: out_data<=data_g, out_sel<=g, out_valid<=1, ptr<=g,
//       beat_cnt<=1.
//     - out_last<=in_last[g] | (MAX_BURST==1).
//     - Stay in IDLE if out_last is set; otherwise go to BURST.
//     If load and no in_valid, out_valid<=0.
//   BURST: the owner is ptr. Only the owner can be accepted; others get
//     in_ready=0.
//     - If load and in_valid[ptr]: accept, beat_cnt++, register the beat.
//     - end = in_last[ptr] | (beat_cnt+1==MAX_BURST); out_last<=end.
//     - On end, go to IDLE.
//     - If load and !in_valid[ptr]: out_valid<=0, stay in BURST
//       (the grant is held through bubbles).
//  Throughput: one beat per cycle when out_ready is held at 1; no dead
//   cycle between bursts.
//  Latency: an accepted beat appears on out_* on the next clk edge.
//  Stall: while out_valid & !out_ready, out_* hold stable, in_ready=0 and
//   no state change.
//  Forced release: the next arbitration starts after ptr. The truncated
//   source may re-request and competes normally.
//  in_valid deasserting without a handshake is legal; the arbiter does not
//   latch requests.
//  beat_cnt width is clog2(MAX_BURST+1) and it never wraps.
//  Reset mid-burst: everything returns to reset values immediately. The
//   pending out beat is dropped.
// TESTING
//  1. Reset, then all four in_valid=1, in_last=1, out_ready=1 -> out_sel
//     sequence 0,1,2,3,0; one beat per cycle; out_last=1 on each beat.
//  2. Src1 bursts 3 beats (A1,A2,A3 with last on A3) while src2 is valid
//     -> out_data A1,A2,A3 with out_sel=1, then src2 is granted;
//     in_ready[2]=0 throughout.
//  3. Src0 streams with in_last=0, MAX_BURST=16 -> beat 16 has out_last=1,
//     then src1 (valid) is granted next.
//  4. out_ready=0 for 5 cycles with out_valid=1, data 0xBEEF -> out_data
//     holds 0xBEEF, in_ready=4'b0000; on release 0xBEEF is consumed once.
//  5. Src3 pauses mid-burst for 2 cycles while src0 is valid -> out_valid=0
//     for those cycles; src0 is not granted until src3 sends last.
//  6. Assert rst mid-burst -> out_valid=0 immediately; after release, the
//     first grant goes to the lowest valid source from 0.

Source files
------------

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin burst arbiter for four valid/ready/last sources onto one registered beat; 1-cycle accept-to-output latency.
// Backpressure: when out_valid is held without out_ready, all in_ready drop and the output register and grant state freeze.
module mux_4to1_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_valid,
    input  logic [3:0]           in_last,
    input  logic [WIDTH-1:0]     data0,
    input  logic [WIDTH-1:0]     data1,
    input  logic [WIDTH-1:0]     data2,
    input  logic [WIDTH-1:0]     data3,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SEL_WIDTH-1:0] out_sel,
    input  logic                 out_ready
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    typedef struct packed {
        logic                 vld;
        logic                 lst;
        logic [SEL_WIDTH-1:0] sel;
        logic [WIDTH-1:0]     dat;
    } beat_t;

    state_t               state_q, state_d;
    beat_t                beat_q, beat_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic [WIDTH-1:0]     src_dat [4];
    logic                 load;
    logic                 win_found;
    logic [SEL_WIDTH-1:0] win_idx;
    logic                 acc;
    logic [SEL_WIDTH-1:0] acc_idx;
    logic [CNT_W-1:0]     cnt_next;
    logic                 burst_end;
    logic [3:0]           ready_raw;

    assign src_dat[0] = data0;
    assign src_dat[1] = data1;
    assign src_dat[2] = data2;
    assign src_dat[3] = data3;

    // The output register can take a new beat when empty or being drained this cycle.
    assign load = !beat_q.vld || out_ready;

    // Search ptr+1, ptr+2, ... wrapping mod 4; k=4 lands back on ptr itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && in_valid[ptr_q + SEL_WIDTH'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + SEL_WIDTH'(k);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        beat_d     = beat_q;
        ready_raw  = 4'b0000;
        acc        = 1'b0;
        acc_idx    = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (load && win_found) begin
                    acc     = 1'b1;
                    acc_idx = win_idx;
                end
            end
            ST_BURST: begin
                if (load && in_valid[ptr_q]) begin
                    acc     = 1'b1;
                    acc_idx = ptr_q;
                end
            end
            default: ;
        endcase

        // A fresh grant counts as beat 1, so MAX_BURST==1 ends every burst immediately.
        cnt_next  = (state_q == ST_IDLE) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
        burst_end = in_last[acc_idx] || (cnt_next == CNT_W'(MAX_BURST));

        if (acc) begin
            ready_raw[acc_idx] = 1'b1;
            beat_d.vld         = 1'b1;
            beat_d.lst         = burst_end;
            beat_d.sel         = acc_idx;
            beat_d.dat         = src_dat[acc_idx];
            ptr_d              = acc_idx;
            beat_cnt_d         = cnt_next;
            state_d            = burst_end ? ST_IDLE : ST_BURST;
        end else if (load) begin
            // Bubble: the grant (if any) is held, only the output goes empty.
            beat_d.vld = 1'b0;
        end
    end

    assign in_ready  = rst ? 4'b0000 : ready_raw;
    assign out_valid = beat_q.vld;
    assign out_last  = beat_q.lst;
    assign out_sel   = beat_q.sel;
    assign out_data  = beat_q.dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            ptr_q      <= '1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Bench for mux_4to1_rr_arbiter: directed vector table, corner sequences, randomized run against a burst-level model.
module tb_mux_4to1_rr_arbiter;

    localparam int MB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = 4'b0000;
    logic [3:0]  in_last = 4'b0000;
    logic [15:0] din [4];
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mux_4to1_rr_arbiter #(.WIDTH(16), .SEL_WIDTH(2), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_last(in_last),
        .data0(din[0]), .data1(din[1]), .data2(din[2]), .data3(din[3]),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        rdy;
        logic [15:0] dat;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        logic [1:0]  exp_sel;
        logic        exp_lst;
        logic [15:0] exp_dat;
    } vec_t;

    vec_t vt [10];

    // Burst-level reference: who owns the path, how many beats it has had, who won last.
    int          m_owner;
    int          m_last_winner;
    int          m_beats;
    logic        m_vld;
    logic        m_lst;
    logic [15:0] m_dat;
    int          m_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic r);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(4'b0000, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_owner       = -1;
        m_last_winner = 3;
        m_beats       = 0;
        m_vld         = 1'b0;
        m_lst         = 1'b0;
        m_dat         = 16'h0000;
        m_sel         = 0;
    endtask

    function automatic int model_grant(input logic [3:0] v, input logic r);
        if (m_vld && !r) return -1;
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        for (int k = 1; k <= 4; k++) begin
            if (v[(m_last_winner + k) % 4]) return (m_last_winner + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int g, input logic was_load);
        if (was_load) begin
            if (g >= 0) begin
                m_beats       = (m_owner < 0) ? 1 : m_beats + 1;
                m_vld         = 1'b1;
                m_dat         = din[g];
                m_sel         = g;
                m_lst         = in_last[g] || (m_beats == MB);
                m_owner       = m_lst ? -1 : g;
                m_last_winner = g;
            end else begin
                m_vld = 1'b0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected simulation to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        logic was_load;
        logic [3:0] exp_r;

        for (int s = 0; s < 4; s++) din[s] = 16'h0000;

        vt[0] = '{4'hF, 4'hF, 1'b1, 16'h0100, 4'b0001, 1'b1, 2'd0, 1'b1, 16'h0100};
        vt[1] = '{4'hF, 4'hF, 1'b1, 16'h0101, 4'b0010, 1'b1, 2'd1, 1'b1, 16'h1101};
        vt[2] = '{4'hF, 4'hF, 1'b1, 16'h0102, 4'b0100, 1'b1, 2'd2, 1'b1, 16'h2102};
        vt[3] = '{4'hF, 4'hF, 1'b1, 16'h0103, 4'b1000, 1'b1, 2'd3, 1'b1, 16'h3103};
        vt[4] = '{4'hF, 4'hF, 1'b1, 16'h0104, 4'b0001, 1'b1, 2'd0, 1'b1, 16'h0104};
        vt[5] = '{4'h6, 4'h0, 1'b1, 16'h0A01, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h1A01};
        vt[6] = '{4'h6, 4'h0, 1'b1, 16'h0A02, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h1A02};
        vt[7] = '{4'h6, 4'h2, 1'b1, 16'h0A03, 4'b0010, 1'b1, 2'd1, 1'b1, 16'h1A03};
        vt[8] = '{4'h4, 4'h4, 1'b1, 16'h0B00, 4'b0100, 1'b1, 2'd2, 1'b1, 16'h2B00};
        vt[9] = '{4'h0, 4'h0, 1'b1, 16'h0000, 4'b0000, 1'b0, 2'd2, 1'b1, 16'h2B00};

        // Reset state, with every source requesting.
        set_in(4'hF, 4'hF, 1'b1);
        tick();
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_data", {16'd0, out_data}, 32'd0);
        chk("rst out_last", {31'd0, out_last}, 32'd0);
        chk("rst out_sel", {30'd0, out_sel}, 32'd0);
        chk("rst in_ready", {28'd0, in_ready}, 32'd0);
        rst = 1'b0;

        // Rotation through all four sources, then a 3-beat burst from src1 blocking src2.
        for (int i = 0; i < 10; i++) begin
            for (int s = 0; s < 4; s++) din[s] = vt[i].dat + 16'(s * 16'h1000);
            set_in(vt[i].v, vt[i].l, vt[i].rdy);
            #1;
            chk($sformatf("vec%0d in_ready", i), {28'd0, in_ready}, {28'd0, vt[i].exp_rdy});
            tick();
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].exp_vld});
            if (vt[i].exp_vld) begin
                chk($sformatf("vec%0d out_sel", i), {30'd0, out_sel}, {30'd0, vt[i].exp_sel});
                chk($sformatf("vec%0d out_last", i), {31'd0, out_last}, {31'd0, vt[i].exp_lst});
                chk($sformatf("vec%0d out_data", i), {16'd0, out_data}, {16'd0, vt[i].exp_dat});
            end
        end

        // Forced release after MAX_BURST beats, then src1 takes over.
        do_reset();
        din[1] = 16'h5151;
        set_in(4'b0011, 4'b0000, 1'b1);
        for (int b = 1; b <= MB; b++) begin
            din[0] = 16'(b);
            #1;
            chk($sformatf("force b%0d in_ready", b), {28'd0, in_ready}, 32'b0001);
            tick();
            chk($sformatf("force b%0d out_sel", b), {30'd0, out_sel}, 32'd0);
            chk($sformatf("force b%0d out_data", b), {16'd0, out_data}, b);
            chk($sformatf("force b%0d out_last", b), {31'd0, out_last}, (b == MB) ? 32'd1 : 32'd0);
        end
        #1;
        chk("force next in_ready", {28'd0, in_ready}, 32'b0010);
        tick();
        chk("force next out_sel", {30'd0, out_sel}, 32'd1);
        chk("force next out_data", {16'd0, out_data}, 32'h5151);

        // Downstream stall holds 0xBEEF for 5 cycles, then it drains exactly once.
        do_reset();
        din[0] = 16'hBEEF;
        set_in(4'b0001, 4'b0001, 1'b1);
        tick();
        chk("stall load out_data", {16'd0, out_data}, 32'hBEEF);
        din[0] = 16'h1234;
        set_in(4'b0001, 4'b0001, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall c%0d in_ready", c), {28'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("stall c%0d out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall c%0d out_data", c), {16'd0, out_data}, 32'hBEEF);
        end
        set_in(4'b0000, 4'b0000, 1'b1);
        tick();
        chk("stall drained out_valid", {31'd0, out_valid}, 32'd0);

        // Src3 pauses mid-burst while src0 waits; grant is held through the bubbles.
        do_reset();
        din[3] = 16'h3333;
        din[0] = 16'h0A0A;
        set_in(4'b1000, 4'b0000, 1'b1);
        #1;
        chk("pause first in_ready", {28'd0, in_ready}, 32'b1000);
        tick();
        chk("pause first out_sel", {30'd0, out_sel}, 32'd3);
        for (int c = 0; c < 2; c++) begin
            set_in(4'b0001, 4'b0000, 1'b1);
            #1;
            chk($sformatf("pause c%0d in_ready", c), {28'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("pause c%0d out_valid", c), {31'd0, out_valid}, 32'd0);
        end
        set_in(4'b1001, 4'b1000, 1'b1);
        #1;
        chk("pause last in_ready", {28'd0, in_ready}, 32'b1000);
        tick();
        chk("pause last out_sel", {30'd0, out_sel}, 32'd3);
        chk("pause last out_last", {31'd0, out_last}, 32'd1);
        set_in(4'b0001, 4'b0001, 1'b1);
        #1;
        chk("pause src0 in_ready", {28'd0, in_ready}, 32'b0001);
        tick();
        chk("pause src0 out_data", {16'd0, out_data}, 32'h0A0A);

        // Reset asserted mid-burst drops the pending beat and restarts from source 0.
        do_reset();
        din[2] = 16'h2222;
        set_in(4'b0100, 4'b0000, 1'b1);
        tick();
        chk("midrst burst out_sel", {30'd0, out_sel}, 32'd2);
        set_in(4'b0110, 4'b0000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst in_ready", {28'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        din[1] = 16'h1111;
        #1;
        chk("midrst regrant in_ready", {28'd0, in_ready}, 32'b0010);
        tick();
        chk("midrst regrant out_sel", {30'd0, out_sel}, 32'd1);
        chk("midrst regrant out_data", {16'd0, out_data}, 32'h1111);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            in_valid = 4'($urandom);
            for (int s = 0; s < 4; s++) begin
                in_last[s] = (n < 1500) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
                din[s]     = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g        = model_grant(in_valid, out_ready);
            was_load = !m_vld || out_ready;
            exp_r    = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("rand in_ready", {28'd0, in_ready}, {28'd0, exp_r});
            tick();
            model_step(g, was_load);
            chk("rand out_valid", {31'd0, out_valid}, {31'd0, m_vld});
            if (m_vld) begin
                chk("rand out_sel", {30'd0, out_sel}, 32'(m_sel));
                chk("rand out_last", {31'd0, out_last}, {31'd0, m_lst});
                chk("rand out_data", {16'd0, out_data}, {16'd0, m_dat});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
